ee354_gcd_sweep_ctrl: RTL and testbench



---
 rtl/ee354_gcd_sweep_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ee354_gcd_sweep_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ee354_gcd_sweep_ctrl.sv
// Sweep controller for the ee354_GCD core: walks every (Ain, Bin) pair in
// [Lo, Hi] x [Lo, Hi], runs the Start/Ack handshake for each pair, times the
// core from q_Sub to q_Done and keeps per-sweep statistics.
`timescale 1ns/1ps
module ee354_gcd_sweep_ctrl #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CW      = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          CEN,
  input  logic          Go,
  input  logic [7:0]    Lo,
  input  logic [7:0]    Hi,
  output logic          Start,
  output logic          Ack,
  output logic [7:0]    Ain,
  output logic [7:0]    Bin,
  input  logic          q_Sub,
  input  logic          q_Done,
  input  logic [7:0]    AB_GCD,
  output logic          Res_Valid,
  output logic [7:0]    Res_GCD,
  output logic [CW-1:0] Res_Clocks,
  output logic [15:0]   Pair_Count,
  output logic [CW-1:0] Max_Clocks,
  output logic [7:0]    Max_Ain,
  output logic [7:0]    Max_Bin,
  output logic          Busy,
  output logic          Done,
  output logic          Error
);

  localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WSUB, S_WDONE, S_ACK, S_NEXT, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    ain_q, ain_d, bin_q, bin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_gcd_q, res_gcd_d;
  logic [CW-1:0] res_clk_q, res_clk_d;
  logic [15:0]   pair_cnt_q, pair_cnt_d;
  logic [CW-1:0] max_clk_q, max_clk_d;
  logic [7:0]    max_a_q, max_a_d, max_b_q, max_b_d;
  logic          err_q, err_d;
  logic [CW-1:0] meas;

  // Next-state and datapath updates; everything defaults to hold.
  always_comb begin
    state_d     = state_q;
    ain_d       = ain_q;
    bin_d       = bin_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    res_valid_d = 1'b0;
    res_gcd_d   = res_gcd_q;
    res_clk_d   = res_clk_q;
    pair_cnt_d  = pair_cnt_q;
    max_clk_d   = max_clk_q;
    max_a_d     = max_a_q;
    max_b_d     = max_b_q;
    err_d       = err_q;
    // q_Done seen while still waiting for q_Sub counts as zero clocks
    meas        = (state_q == S_WSUB) ? '0 : cnt_q;

    unique case (state_q)
      S_IDLE, S_FIN: begin
        if (Go) begin
          pair_cnt_d = '0;
          max_clk_d  = '0;
          max_a_d    = '0;
          max_b_d    = '0;
          err_d      = 1'b0;
          timer_d    = '0;
          if (Lo == '0) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (Lo > Hi) begin
            state_d = S_FIN;
          end else begin
            ain_d   = Lo;
            bin_d   = Lo;
            state_d = S_START;
          end
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WSUB;
      end
      S_WSUB, S_WDONE: begin
        if (q_Done) begin
          res_gcd_d   = AB_GCD;
          res_clk_d   = meas;
          res_valid_d = 1'b1;
          pair_cnt_d  = pair_cnt_q + 16'd1;
          if (meas > max_clk_q) begin
            max_clk_d = meas;
            max_a_d   = ain_q;
            max_b_d   = bin_q;
          end
          state_d = S_ACK;
        end else if (timer_q == TMAX) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          timer_d = timer_q + TW'(1);
          if (state_q == S_WSUB) begin
            if (q_Sub) begin
              cnt_d   = '0;
              state_d = S_WDONE;
            end
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_ACK: state_d = S_NEXT;
      S_NEXT: begin
        // equality compares so Hi=255 terminates without wrapping
        if (bin_q != Hi) begin
          bin_d   = bin_q + 8'd1;
          state_d = S_START;
        end else if (ain_q != Hi) begin
          ain_d   = ain_q + 8'd1;
          bin_d   = Lo;
          state_d = S_START;
        end else begin
          state_d = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; Reset wins over CEN, CEN=0 holds all.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      ain_q       <= '0;
      bin_q       <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      res_valid_q <= 1'b0;
      res_gcd_q   <= '0;
      res_clk_q   <= '0;
      pair_cnt_q  <= '0;
      max_clk_q   <= '0;
      max_a_q     <= '0;
      max_b_q     <= '0;
      err_q       <= 1'b0;
    end else if (CEN) begin
      state_q     <= state_d;
      ain_q       <= ain_d;
      bin_q       <= bin_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      res_valid_q <= res_valid_d;
      res_gcd_q   <= res_gcd_d;
      res_clk_q   <= res_clk_d;
      pair_cnt_q  <= pair_cnt_d;
      max_clk_q   <= max_clk_d;
      max_a_q     <= max_a_d;
      max_b_q     <= max_b_d;
      err_q       <= err_d;
    end
  end

  // Start/Ack decode the state register, so they freeze with CEN and drop
  // the cycle after Reset or a timeout.
  assign Start      = (state_q == S_START);
  assign Ack        = (state_q == S_ACK);
  assign Busy       = (state_q != S_IDLE) && (state_q != S_FIN);
  assign Done       = (state_q == S_FIN);
  assign Ain        = ain_q;
  assign Bin        = bin_q;
  assign Res_Valid  = res_valid_q;
  assign Res_GCD    = res_gcd_q;
  assign Res_Clocks = res_clk_q;
  assign Pair_Count = pair_cnt_q;
  assign Max_Clocks = max_clk_q;
  assign Max_Ain    = max_a_q;
  assign Max_Bin    = max_b_q;
  assign Error      = err_q;

endmodule

// File: tb/tb_ee354_gcd_sweep_ctrl.sv
// Bench for ee354_gcd_sweep_ctrl with a behavioural subtract-loop GCD core.
`timescale 1ns/1ps
module tb_ee354_gcd_sweep_ctrl;

  localparam int unsigned TIMEOUT = 1023;
  localparam int unsigned CW      = 10;

  logic          Clk = 1'b0;
  logic          Reset, CEN, Go;
  logic [7:0]    Lo, Hi;
  logic          Start, Ack;
  logic [7:0]    Ain, Bin;
  logic          q_Sub, q_Done;
  logic [7:0]    AB_GCD;
  logic          Res_Valid;
  logic [7:0]    Res_GCD;
  logic [CW-1:0] Res_Clocks;
  logic [15:0]   Pair_Count;
  logic [CW-1:0] Max_Clocks;
  logic [7:0]    Max_Ain, Max_Bin;
  logic          Busy, Done, Error;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  always #5 Clk = ~Clk;

  ee354_gcd_sweep_ctrl #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
    .Clk(Clk), .Reset(Reset), .CEN(CEN), .Go(Go), .Lo(Lo), .Hi(Hi),
    .Start(Start), .Ack(Ack), .Ain(Ain), .Bin(Bin),
    .q_Sub(q_Sub), .q_Done(q_Done), .AB_GCD(AB_GCD),
    .Res_Valid(Res_Valid), .Res_GCD(Res_GCD), .Res_Clocks(Res_Clocks),
    .Pair_Count(Pair_Count), .Max_Clocks(Max_Clocks),
    .Max_Ain(Max_Ain), .Max_Bin(Max_Bin),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  // Behavioural GCD core: one subtraction (or equality test) per enabled clock.
  typedef enum logic [1:0] {C_INI, C_SUB, C_DONE} core_t;
  core_t      cst;
  logic [7:0] ca, cb;
  logic       hang = 1'b0;

  always @(posedge Clk) begin
    if (Reset) begin
      cst <= C_INI; ca <= 8'd0; cb <= 8'd0;
    end else if (CEN) begin
      case (cst)
        C_INI:  if (Start && !hang) begin ca <= Ain; cb <= Bin; cst <= C_SUB; end
        C_SUB:  if (ca == cb) cst <= C_DONE;
                else if (ca > cb) ca <= ca - cb;
                else cb <= cb - ca;
        C_DONE: if (Ack) cst <= C_INI;
        default: cst <= C_INI;
      endcase
    end
  end
  assign q_Sub  = (cst == C_SUB);
  assign q_Done = (cst == C_DONE);
  assign AB_GCD = ca;

  function automatic int unsigned sw_gcd(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  // clocks from q_Sub to q_Done equal the number of subtractions
  function automatic int unsigned sw_steps(input int unsigned a, input int unsigned b);
    int unsigned n = 0;
    if (a == 0 || b == 0) return 0;
    while (a != b) begin
      if (a > b) a = a - b; else b = b - a;
      n++;
    end
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: expected pair order and results for every strobe.
  int unsigned sb_lo = 0, sb_hi = 0, sb_a = 0, sb_b = 0, sb_n = 0;
  int unsigned sb_max = 0, sb_ma = 0, sb_mb = 0;

  always @(negedge Clk) begin
    if (Reset === 1'b0 && CEN === 1'b1 && Res_Valid === 1'b1) begin
      int unsigned st;
      st = sw_steps(sb_a, sb_b);
      chk("pair_ain", 32'(Ain), sb_a);
      chk("pair_bin", 32'(Bin), sb_b);
      chk("res_gcd", 32'(Res_GCD), sw_gcd(sb_a, sb_b));
      chk("res_clocks", 32'(Res_Clocks), st);
      sb_n++;
      chk("pair_count_live", 32'(Pair_Count), sb_n);
      if (st > sb_max) begin sb_max = st; sb_ma = sb_a; sb_mb = sb_b; end
      if (sb_b != sb_hi) sb_b++;
      else begin sb_a++; sb_b = sb_lo; end
    end
  end

  task automatic start_sweep(input int unsigned lo, input int unsigned hi);
    @(negedge Clk);
    Lo = 8'(lo); Hi = 8'(hi);
    sb_lo = lo; sb_hi = hi; sb_a = lo; sb_b = lo; sb_n = 0;
    sb_max = 0; sb_ma = 0; sb_mb = 0;
    Go = 1'b1;
    @(negedge Clk);
    Go = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, output int unsigned used);
    used = 0;
    while (Done !== 1'b1 && used < budget) begin @(negedge Clk); used++; end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, 32'({Start, Ack, Res_Valid, Busy, Done, Error}), 32'd0);
    chk({tag, "_pair"}, 32'({Ain, Bin}), 32'd0);
    chk({tag, "_res"}, 32'({Res_GCD, Res_Clocks}), 32'd0);
    chk({tag, "_cnt"}, 32'(Pair_Count), 32'd0);
    chk({tag, "_max"}, 32'({Max_Clocks, Max_Ain, Max_Bin}), 32'd0);
  endtask

  typedef struct {
    int unsigned lo, hi, pairs;
    logic        err, use_model;
    int unsigned mclk, ma, mb;
  } vec_t;

  vec_t        vecs[6];
  int unsigned used, n, w;

  initial begin
    vecs[0] = '{lo:0,   hi:3,   pairs:0,    err:1'b1, use_model:1'b0, mclk:0,   ma:0,   mb:0};
    vecs[1] = '{lo:2,   hi:3,   pairs:4,    err:1'b0, use_model:1'b0, mclk:2,   ma:2,   mb:3};
    vecs[2] = '{lo:7,   hi:7,   pairs:1,    err:1'b0, use_model:1'b0, mclk:0,   ma:0,   mb:0};
    vecs[3] = '{lo:5,   hi:4,   pairs:0,    err:1'b0, use_model:1'b0, mclk:0,   ma:0,   mb:0};
    vecs[4] = '{lo:254, hi:255, pairs:4,    err:1'b0, use_model:1'b0, mclk:254, ma:254, mb:255};
    vecs[5] = '{lo:2,   hi:63,  pairs:3844, err:1'b0, use_model:1'b1, mclk:0,   ma:0,   mb:0};

    Reset = 1'b1; CEN = 1'b1; Go = 1'b0; Lo = 8'd0; Hi = 8'd0;
    repeat (3) @(negedge Clk);
    chk_zero("reset");
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 6; i++) begin
      start_sweep(vecs[i].lo, vecs[i].hi);
      wait_done(90000, used);
      chk("vec_done", 32'({Done, Busy}), 32'b10);
      chk("vec_error", 32'(Error), 32'(vecs[i].err));
      chk("vec_pairs", 32'(Pair_Count), vecs[i].pairs);
      chk("vec_strobes", sb_n, vecs[i].pairs);
      if (vecs[i].pairs == 0) chk("vec_fin_latency", used, 32'd0);
      if (vecs[i].use_model) begin
        chk("vec_max_clk", 32'(Max_Clocks), sb_max);
        chk("vec_max_pair", 32'({Max_Ain, Max_Bin}), (sb_ma << 8) | sb_mb);
      end else begin
        chk("vec_max_clk", 32'(Max_Clocks), vecs[i].mclk);
        chk("vec_max_pair", 32'({Max_Ain, Max_Bin}), (vecs[i].ma << 8) | vecs[i].mb);
      end
    end

    // CEN stall inside S_WDONE of pair (5,6): five subtractions either way.
    start_sweep(5, 6);
    n = 0;
    while (!(Start === 1'b1 && Bin === 8'd6) && n < 200) begin @(negedge Clk); n++; end
    chk("stall_found", 32'({Start, Ain, Bin}), {23'd0, 1'b1, 8'd5, 8'd6});
    repeat (3) @(negedge Clk);
    CEN = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clk);
      chk("stall_ctl", 32'({Start, Ack, Busy, Done, Res_Valid, Error, q_Sub}), 32'b0010001);
      chk("stall_pair", 32'({Ain, Bin}), {16'd0, 8'd5, 8'd6});
      chk("stall_cnt", 32'(Pair_Count), 32'd1);
      chk("stall_res", 32'({Res_GCD, Res_Clocks}), {14'd0, 8'd5, 10'd0});
    end
    CEN = 1'b1;
    n = 0;
    while (Res_Valid !== 1'b1 && n < 50) begin @(negedge Clk); n++; end
    chk("stall_clocks", 32'({Res_Valid, Res_Clocks}), {21'd0, 1'b1, 10'd5});
    wait_done(500, used);
    chk("stall_end_cnt", 32'({Done, Pair_Count}), {15'd0, 1'b1, 16'd4});
    chk("stall_end_max", 32'({Max_Clocks, Max_Ain, Max_Bin}), {6'd0, 10'd5, 8'd5, 8'd6});

    // Core stops answering after two pairs: timeout aborts the third.
    start_sweep(2, 3);
    n = 0;
    while (Pair_Count !== 16'd2 && n < 200) begin @(negedge Clk); n++; end
    hang = 1'b1;
    n = 0;
    while (Start !== 1'b1 && n < 50) begin @(negedge Clk); n++; end
    chk("to_start_seen", 32'(Start), 32'd1);
    w = 0;
    @(negedge Clk);
    while (Busy === 1'b1 && w < 3000) begin w++; @(negedge Clk); end
    chk("to_cycles", w, TIMEOUT + 1);
    chk("to_flags", 32'({Error, Done, Start, Ack, Busy}), 32'b11000);
    chk("to_pairs", 32'(Pair_Count), 32'd2);
    hang = 1'b0;

    // Reset while in S_START of the third pair, then a clean restart.
    start_sweep(3, 4);
    n = 0;
    while (!(Start === 1'b1 && Pair_Count === 16'd2) && n < 200) begin @(negedge Clk); n++; end
    chk("rst_found", 32'({Start, Ain, Bin}), {23'd0, 1'b1, 8'd4, 8'd3});
    Reset = 1'b1;
    @(negedge Clk);
    chk_zero("rst_mid");
    Reset = 1'b0;
    start_sweep(3, 4);
    n = 0;
    while (Start !== 1'b1 && n < 20) begin @(negedge Clk); n++; end
    chk("rst_restart", 32'({Start, Ain, Bin}), {23'd0, 1'b1, 8'd3, 8'd3});
    wait_done(500, used);
    chk("rst_end", 32'({Done, Error, Pair_Count}), {14'd0, 2'b10, 16'd4});
    chk("rst_max", 32'({Max_Clocks, Max_Ain, Max_Bin}), {6'd0, 10'd3, 8'd3, 8'd4});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
